sa_feeder: RTL and testbench

Upstream sequencer for the 2x2 systolic array: buffers a job of K operand beats, issues the `clear` pulse, then replays the beats into the array edges with diagonal skew (row 1 / column 1 delayed one cycle), waits for the array to drain, and returns the array's 8-bit `out` sum as a single result. One job is in flight at a time, and each job computes sum over k of (a0[k]·b0[k] + a1[k]·b1[k]) mod 256.

---
 rtl/sa_pkg.sv | 7 +
 rtl/sa_skew_reg.sv | 11 +
 rtl/sa_feeder.sv | 118 +++++++++++
 tb/tb_sa_feeder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding and default sizing for the systolic-array feeder.
package sa_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_FEED, S_DRAIN, S_RESULT} state_t;
  localparam int SA_DATA_W = 8;
  localparam int SA_DEPTH  = 8;
  localparam int SA_DRAIN  = 3;
endpackage

// File: rtl/sa_skew_reg.sv
// sa_skew_reg: one-cycle delay register with synchronous clear, used for row-1/column-1 skew.
module sa_skew_reg
  import sa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SA_DATA_W-1:0] d,
  output logic [SA_DATA_W-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : d;
endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: buffers a job of operand beats and replays them skewed into a 2x2 systolic array.
// Optional SA_FEEDER_JOBCNT_EN adds a 16-bit completed-job counter output.
module sa_feeder
  import sa_pkg::*;
#(
  parameter int DEPTH = SA_DEPTH,
  parameter int DRAIN = SA_DRAIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SA_DATA_W-1:0] in_a0,
  input  logic [SA_DATA_W-1:0] in_a1,
  input  logic [SA_DATA_W-1:0] in_b0,
  input  logic [SA_DATA_W-1:0] in_b1,
  input  logic                 in_last,
  output logic                 clear,
  output logic [SA_DATA_W-1:0] din0,
  output logic [SA_DATA_W-1:0] din1,
  output logic [SA_DATA_W-1:0] win0,
  output logic [SA_DATA_W-1:0] win1,
  input  logic [SA_DATA_W-1:0] sa_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SA_DATA_W-1:0] res_data,
  output logic                 busy
`ifdef SA_FEEDER_JOBCNT_EN
  ,
  output logic [15:0]          job_count
`endif
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = DRAIN > 1 ? $clog2(DRAIN) : 1;
  state_t state_q, state_d;
  logic [PW-1:0] wp_q, wp_d, f_q, f_d, wr_idx;
  logic [CW-1:0] dc_q, dc_d;
  logic [4*SA_DATA_W-1:0] mem_q [DEPTH];
  logic accept, last, drain_end, feed_d, feed_q, clear_q, clear_d, res_valid_q, res_valid_d;
  logic [SA_DATA_W-1:0] din0_q, din0_d, win0_q, win0_d, row1_d, col1_d, res_data_q, res_data_d;
  assign in_ready  = state_q == S_IDLE || state_q == S_LOAD;
  assign busy      = state_q != S_IDLE;
  assign accept    = in_valid && in_ready;
  assign wr_idx    = state_q == S_IDLE ? '0 : wp_q;
  assign last      = in_last || wr_idx == PW'(DEPTH - 1);
  assign drain_end = state_q == S_DRAIN && dc_q == CW'(DRAIN - 1);
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    f_d     = f_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE, S_LOAD: if (accept) begin
        wp_d    = wr_idx + 1'b1;
        state_d = last ? S_CLR : S_LOAD;
      end
      S_CLR: begin
        state_d = S_FEED;
        f_d     = '0;
      end
      S_FEED: if (f_q == wp_q) begin
        state_d = S_DRAIN;
        dc_d    = '0;
      end else f_d = f_q + 1'b1;
      S_DRAIN: if (drain_end) state_d = S_RESULT; else dc_d = dc_q + 1'b1;
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // row 0 is registered from the upcoming slot; row 1 taps the current slot and the skew reg delays it
    feed_d      = state_d == S_FEED && f_d < wp_d;
    feed_q      = state_q == S_FEED && f_q < wp_q;
    din0_d      = feed_d ? mem_q[AW'(f_d)][31:24] : '0;
    win0_d      = feed_d ? mem_q[AW'(f_d)][15:8] : '0;
    row1_d      = feed_q ? mem_q[AW'(f_q)][23:16] : '0;
    col1_d      = feed_q ? mem_q[AW'(f_q)][7:0] : '0;
    clear_d     = state_d == S_CLR;
    res_valid_d = state_d == S_RESULT;
    res_data_d  = drain_end ? sa_out : res_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      f_q         <= '0;
      dc_q        <= '0;
      clear_q     <= 1'b0;
      din0_q      <= '0;
      win0_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      f_q         <= f_d;
      dc_q        <= dc_d;
      clear_q     <= clear_d;
      din0_q      <= din0_d;
      win0_q      <= win0_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end
  always_ff @(posedge clk) if (accept) mem_q[AW'(wr_idx)] <= {in_a0, in_a1, in_b0, in_b1};
  sa_skew_reg u_row1 (.clk(clk), .rst(rst), .d(row1_d), .q(din1));
  sa_skew_reg u_col1 (.clk(clk), .rst(rst), .d(col1_d), .q(win1));
  assign clear     = clear_q;
  assign din0      = din0_q;
  assign win0      = win0_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
`ifdef SA_FEEDER_JOBCNT_EN
  logic [15:0] jc_q, jc_d;
  assign jc_d = jc_q + 16'(res_valid_q && res_ready);
  always_ff @(posedge clk) jc_q <= rst ? '0 : jc_d;
  assign job_count = jc_q;
`endif
endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: table-driven checks of sa_feeder against a behavioural 2x2 array model.
module tb_sa_feeder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
  logic [7:0] in_a0 = '0, in_a1 = '0, in_b0 = '0, in_b1 = '0, sa_out;
  logic in_ready, clear, res_valid, busy;
  logic [7:0] din0, din1, win0, win1, res_data;
`ifdef SA_FEEDER_JOBCNT_EN
  logic [15:0] job_count;
`endif
  int n_vec = 0, n_err = 0, jobs = 0;
  typedef struct {
    int k;
    bit use_last;
    bit stall;
    int hold;
    logic [7:0][7:0] a0, a1, b0, b1;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[6];
  sa_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1), .in_last(in_last),
    .clear(clear), .din0(din0), .din1(din1), .win0(win0), .win1(win1),
    .sa_out(sa_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
`ifdef SA_FEEDER_JOBCNT_EN
    , .job_count(job_count)
`endif
  );
  always #5 clk = ~clk;
  // 2x2 array: PE00 accumulates row0*col0, PE11 sees row1/col1 one hop later through PE10/PE01
  logic [7:0] acc00 = '0, acc11 = '0, d11 = '0, w11 = '0;
  always @(posedge clk) begin
    if (clear) begin
      acc00 <= '0;
      acc11 <= '0;
      d11   <= '0;
      w11   <= '0;
    end else begin
      acc00 <= acc00 + din0 * win0;
      d11   <= din1;
      w11   <= win1;
      acc11 <= acc11 + d11 * w11;
    end
  end
  assign sa_out = acc00 + acc11;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_beats(input vec_t v);
    for (int j = 0; j < v.k; j++) begin
      in_valid = 1'b1;
      in_a0 = v.a0[j];
      in_a1 = v.a1[j];
      in_b0 = v.b0[j];
      in_b1 = v.b1[j];
      in_last = v.use_last && j == v.k - 1;
      chk("beat_ready", in_ready, 1);
      step();
    end
    in_valid = v.stall;
    in_a0 = 8'hee;
    in_last = 1'b0;
  endtask
  task automatic run_job(input vec_t v);
    int t, f;
    logic [7:0] e0, e1, f0, f1;
    send_beats(v);
    t = 1;
    forever begin
      f = t - 2;
      {e0, e1, f0, f1} = '0;
      if (t >= 2 && f < v.k) begin
        e0 = v.a0[f];
        f0 = v.b0[f];
      end
      if (f >= 1 && f <= v.k) begin
        e1 = v.a1[f-1];
        f1 = v.b1[f-1];
      end
      chk("feed_cycle", {clear, din0, din1, win0, win1, in_ready, busy},
          {t == 1, e0, e1, f0, f1, 1'b0, 1'b1});
      if (res_valid || t > 40) break;
      step();
      t++;
    end
    chk("latency", t, v.k + 6);
    chk("res_data", res_data, v.exp);
    in_valid = 1'b0;
    repeat (v.hold) begin
      step();
      chk("res_hold", {res_valid, res_data, busy, in_ready}, {1'b1, v.exp, 1'b1, 1'b0});
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    jobs++;
    chk("to_idle", {res_valid, busy, in_ready, clear}, {1'b0, 1'b0, 1'b1, 1'b0});
  endtask
  initial begin
    tbl[0] = '{k:1, use_last:1, stall:0, hold:0, a0:64'd3, a1:64'd4, b0:64'd5, b1:64'd6, exp:8'd39};
    tbl[1] = '{k:4, use_last:1, stall:0, hold:10, a0:64'h02020202, a1:64'h02020202,
               b0:64'h03030303, b1:64'h03030303, exp:8'd48};
    tbl[2] = '{k:8, use_last:0, stall:1, hold:0,
               a0:{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, a1:64'h0101010101010101,
               b0:64'h0101010101010101, b1:64'h0202020202020202, exp:8'd52};
    tbl[3] = '{k:2, use_last:1, stall:0, hold:2, a0:{8'd100, 8'd200}, a1:{8'd1, 8'd16},
               b0:{8'd3, 8'd2}, b1:{8'd5, 8'd16}, exp:8'd193};
    tbl[4] = '{k:3, use_last:1, stall:0, hold:0, a0:{8'd3, 8'd2, 8'd1}, a1:{8'd9, 8'd8, 8'd7},
               b0:{8'd6, 8'd5, 8'd4}, b1:{8'd12, 8'd11, 8'd10}, exp:8'd42};
    tbl[5] = '{k:8, use_last:1, stall:0, hold:1, a0:64'h0101010101010101, a1:64'h0101010101010101,
               b0:64'h0101010101010101, b1:64'h0101010101010101, exp:8'd16};
    step();
    step();
    chk("reset", {in_ready, clear, din0, din1, win0, win1, res_valid, res_data, busy},
        {1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_job(tbl[i]);
    send_beats(tbl[1]);
    step();
    step();
    chk("mid_feed_active", {busy, din0}, {1'b1, 8'd2});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_reset", {in_ready, clear, din0, din1, win0, win1, res_valid, res_data, busy},
        {1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0});
    run_job(tbl[0]);
`ifdef SA_FEEDER_JOBCNT_EN
    chk("job_count", job_count, jobs);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
